// File: rtl/output_pulse_driver_if.sv
// Strobe/level bundle between control logic and the output pulse driver.
interface output_pulse_driver_if;
    logic riseevent;
    logic fallevent;
    logic level;
    logic busy;
    logic changed;
    logic dropped;

    // Control logic side: issues strobes, observes the line.
    modport master (
        output riseevent,
        output fallevent,
        input  level,
        input  busy,
        input  changed,
        input  dropped
    );

    // Driver side.
    modport slave (
        input  riseevent,
        input  fallevent,
        output level,
        output busy,
        output changed,
        output dropped
    );
endinterface

// File: rtl/output_pulse_driver.sv
// Turns rise/fall request strobes into a clean output level in which each value is
// held for at least HoldTime cycles. A one-deep pending slot absorbs requests that
// arrive during the dwell window; the latest request wins.
module output_pulse_driver #(
    parameter int unsigned CounterWidth = 3,
    parameter int unsigned HoldTime     = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    output_pulse_driver_if.slave  drv_if
);

    localparam logic [CounterWidth-1:0] CntMax = CounterWidth'(HoldTime - 1);

    logic                    level_q, level_d;
    logic                    busy_q, busy_d;
    logic                    changed_q, changed_d;
    logic                    dropped_q, dropped_d;
    logic                    pvalid_q, pvalid_d;
    logic                    pval_q, pval_d;
    logic [CounterWidth-1:0] cnt_q, cnt_d;

    logic has_req;
    logic req;
    logic both;
    logic tgt_valid;
    logic tgt_val;

    // Decode the strobes: exactly one set is a request, both set is a conflict.
    always_comb begin
        has_req   = drv_if.riseevent ^ drv_if.fallevent;
        req       = drv_if.riseevent;
        both      = drv_if.riseevent & drv_if.fallevent;
        // At dwell end a same-cycle request takes priority over the pending slot.
        tgt_valid = has_req | pvalid_q;
        tgt_val   = has_req ? req : pval_q;
    end

    // Next-state: idle acceptance, dwell counting/pending capture, end-of-dwell decision.
    always_comb begin
        level_d   = level_q;
        busy_d    = busy_q;
        changed_d = 1'b0;
        dropped_d = both;
        pvalid_d  = pvalid_q;
        pval_d    = pval_q;
        cnt_d     = cnt_q;

        if (!busy_q) begin
            if (has_req && (req != level_q)) begin
                level_d   = req;
                changed_d = 1'b1;
                busy_d    = 1'b1;
                cnt_d     = '0;
            end
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
            if (has_req) begin
                pvalid_d  = 1'b1;
                pval_d    = req;
                dropped_d = dropped_d | pvalid_q;
            end
        end else begin
            pvalid_d  = 1'b0;
            dropped_d = dropped_d | (has_req & pvalid_q);
            if (tgt_valid && (tgt_val != level_q)) begin
                level_d   = tgt_val;
                changed_d = 1'b1;
                cnt_d     = '0;
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    // State register; reset discards any pending request without reporting it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q   <= 1'b0;
            busy_q    <= 1'b0;
            changed_q <= 1'b0;
            dropped_q <= 1'b0;
            pvalid_q  <= 1'b0;
            pval_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            level_q   <= level_d;
            busy_q    <= busy_d;
            changed_q <= changed_d;
            dropped_q <= dropped_d;
            pvalid_q  <= pvalid_d;
            pval_q    <= pval_d;
            cnt_q     <= cnt_d;
        end
    end

    // All outputs come straight from registers.
    always_comb begin
        drv_if.level   = level_q;
        drv_if.busy    = busy_q;
        drv_if.changed = changed_q;
        drv_if.dropped = dropped_q;
    end

endmodule

// File: tb/tb_output_pulse_driver.sv
// Directed and random checks of output_pulse_driver with HoldTime = 6.
module tb_output_pulse_driver;

    logic clk;
    logic reset;
    int   vecs;
    int   errs;

    output_pulse_driver_if drv_if ();

    output_pulse_driver #(
        .CounterWidth (3),
        .HoldTime     (6)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .drv_if (drv_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive strobes for one cycle; outputs are then stable 1 time unit after the edge.
    task automatic cyc(input logic r, input logic f);
        drv_if.riseevent = r;
        drv_if.fallevent = f;
        @(posedge clk);
        #1;
        drv_if.riseevent = 1'b0;
        drv_if.fallevent = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic lv, input logic bs,
                           input logic ch, input logic dr);
        check({tag, ".level"}, drv_if.level, lv);
        check({tag, ".busy"}, drv_if.busy, bs);
        check({tag, ".changed"}, drv_if.changed, ch);
        check({tag, ".dropped"}, drv_if.dropped, dr);
    endtask

    logic last_req;
    logic prev_level;
    int   since_chg;

    initial begin
        vecs = 0;
        errs = 0;
        drv_if.riseevent = 1'b0;
        drv_if.fallevent = 1'b0;
        reset = 1'b1;
        #1;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) cyc(1'b0, 1'b0);
        chk_out("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Rise from idle: one-cycle latency, six-cycle busy window.
        cyc(1'b1, 1'b0);
        chk_out("rise0", 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b0, 1'b0);
            chk_out($sformatf("rise_dwell%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0);
        chk_out("rise_end", 1'b1, 1'b0, 1'b0, 1'b0);

        // Same-level request while idle is ignored silently.
        cyc(1'b1, 1'b0);
        chk_out("same_lvl", 1'b1, 1'b0, 1'b0, 1'b0);

        // Fall, then a rise queued during dwell fires exactly 6 cycles later.
        cyc(1'b0, 1'b1);
        chk_out("fall0", 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk_out("queued", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 3; i <= 5; i++) begin
            cyc(1'b0, 1'b0);
            chk_out($sformatf("hold%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0);
        chk_out("retoggle", 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b0, 1'b0);
            chk_out($sformatf("re_dwell%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0);
        chk_out("re_end", 1'b1, 1'b0, 1'b0, 1'b0);

        // Net-zero rise then fall during a dwell: one drop, no toggle at dwell end.
        cyc(1'b0, 1'b1);
        chk_out("nz_fall", 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk_out("nz_rise", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        chk_out("nz_over", 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk_out("nz_c3", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk_out("nz_c5", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk_out("nz_end", 1'b0, 1'b0, 1'b0, 1'b0);

        // Conflicting strobes while idle.
        cyc(1'b1, 1'b1);
        chk_out("both", 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk_out("both_after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-dwell with a pending fall.
        cyc(1'b1, 1'b0);
        chk_out("rst_rise", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_out("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        prev_level = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0);
            check("post_rst_changed", drv_if.changed, 1'b0);
        end
        chk_out("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk_out("post_rst_rise", 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (8) cyc(1'b0, 1'b0);

        // Random strobe stream: spacing and change/level coherence.
        last_req   = drv_if.level;
        prev_level = drv_if.level;
        since_chg  = 100;
        for (int i = 0; i < 2000; i++) begin
            logic r;
            logic f;
            r = ($urandom_range(0, 5) == 0);
            f = ($urandom_range(0, 5) == 0);
            if (r ^ f) last_req = r;
            cyc(r, f);
            since_chg++;
            if (drv_if.changed === 1'b1) begin
                check("rnd_spacing", (since_chg >= 6), 1'b1);
                since_chg = 0;
            end
            check("rnd_chg_coh", drv_if.changed, (drv_if.level !== prev_level));
            prev_level = drv_if.level;
        end
        repeat (20) cyc(1'b0, 1'b0);
        check("rnd_quiet_busy", drv_if.busy, 1'b0);
        check("rnd_final_level", drv_if.level, last_req);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/output_pulse_driver.md
Name: output_pulse_driver

Overview:
- Transmit-side counterpart of the input conditioner: turns single-cycle edge-request pulses back into a clean, glitch-free level on one output line.
- Each level is held for a guaranteed minimum dwell, so a debouncing receiver at the far end accepts every transition.
- Sits between internal control logic, which issues rise/fall strobes, and an output pin or inter-block wire.

Parameters:
- counterwidth, 3, dwell counter width in bits; must satisfy 2^counterwidth > holdtime-1.
- holdtime, 6, minimum cycles each output level is held. 6 covers a receiver with a 2-flop synchronizer plus a debounce wait of 3.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- riseevent  input  1  one-cycle request: drive line high
- fallevent  input  1  one-cycle request: drive line low
- level  output  1  driven line, registered
- busy  output  1  high while the current level is within its dwell window
- changed  output  1  one-cycle pulse on the cycle level takes a new value
- dropped  output  1  one-cycle pulse when a request is discarded or overwritten

Behaviour:
- Reset (async, active-high): level=0, busy=0, changed=0, dropped=0, counter=0, pending cleared. All state updates on posedge clk otherwise.
- Request decode per cycle:
  - rise only -> req=1
  - fall only -> req=0
  - both -> no request; dropped=1 next cycle
  - neither -> no request
- Idle (busy=0):
  - Request with req!=level: on the next edge level<=req, changed=1, busy=1, counter<=0. Latency is exactly 1 cycle.
  - Request with req==level: ignored, no dropped.
- Dwell (busy=1):
  - counter increments each cycle from 0 to holdtime-1.
  - Any request is stored in a one-deep pending register as target value (pvalid=1, pval=req).
  - If pvalid was already set, the new request overwrites it and dropped=1 for one cycle.
- End of dwell, on the edge where counter==holdtime-1:
  - Effective target = request arriving this cycle if any, else pending.
  - If the target is valid and differs from level: level toggles, changed=1, counter<=0, busy stays 1.
  - Otherwise busy<=0.
  - Pending is cleared in both cases. If a same-cycle request overwrote a valid pending entry, dropped=1.
- A pending entry equal to the current level is consumed silently. This makes net-zero sequences, e.g. rise then fall within one dwell, collapse to no transition.
- Invariants:
  - level never changes on two edges fewer than holdtime cycles apart.
  - changed and level transitions coincide exactly.
  - changed, dropped and level are all registered; no combinational path from inputs to outputs.
- Counter never wraps; it saturates by construction at holdtime-1.
- Reset asserted mid-dwell: all state clears immediately. A pending request is lost with no dropped pulse. The first post-reset request obeys idle rules.

Test Plan:
- Reset then riseevent at cycle 10 -> level=1 and changed=1 at cycle 11; busy high cycles 11-16; busy=0 at cycle 17.
- Idle with level=1, fallevent at cycle 30 -> level=0 at 31. riseevent at 33 -> level stays 0 until it rises at cycle 37, exactly 6 cycles after 31. changed pulses at 31 and 37; busy continuous from 31 to 42.
- During dwell, riseevent then fallevent on consecutive cycles -> dropped=1 once, after the second. At dwell end the target equals level, so no toggle and busy falls.
- riseevent and fallevent together while idle -> level unchanged, changed=0, dropped=1 on the next cycle.
- Reset pulse asserted asynchronously mid-dwell with a pending fall -> level=0, busy=0, dropped=0 immediately; no transition after reset deasserts.
- Random strobe stream over 2000 cycles -> every interval between changed pulses is at least 6 cycles; level equals the last accepted request once the line is quiescent.
